// File: rtl/mcp3204_responder_if.sv
// SPI pin bundle between an MCP3204-style master and the responder.
// miso is only meaningful while miso_oe is high.
interface mcp3204_responder_if;
   logic sclk;
   logic cs_n;
   logic mosi;
   logic miso;
   logic miso_oe;

   modport master (
      output sclk, cs_n, mosi,
      input  miso, miso_oe
   );

   modport slave (
      input  sclk, cs_n, mosi,
      output miso, miso_oe
   );
endinterface

// File: rtl/mcp3204_responder.sv
// Oversampled SPI responder emulating an MCP3204 4-channel 12-bit ADC.
// Host-written channel registers supply the value returned in each frame.
module mcp3204_responder #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [11:0] RESET_VALUE = 12'h000,
   parameter int          COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   mcp3204_responder_if.slave     spi,
   input  logic                   wr_en,
   input  logic [1:0]             wr_addr,
   input  logic [11:0]            wr_data,
   output logic                   conv_done,
   output logic [2:0]             conv_chan,
   output logic [COUNT_WIDTH-1:0] conv_count
);

   typedef enum logic [2:0] {
      IDLE, WAIT_START, CMD, SAMPLE, DATA, TRAIL
   } state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
   logic rise, fall, cs_rise, cs_fall;

   logic [11:0] ch [4];
   logic [11:0] ch_a, ch_b, result, sh, sh_n;
   logic [12:0] diff;
   logic [3:0]  cnt, cnt_n;
   logic [2:0]  cmd, cmd_n, chan_n;
   logic        miso_q, miso_n, oe_q, oe_n, done_n;
   logic [COUNT_WIDTH-1:0] count_n;

   // cs_n sync resets low so a cs_n held low across reset never looks like a fall
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   assign sclk_s  = sclk_sync[SYNC_STAGES-1];
   assign cs_s    = cs_sync[SYNC_STAGES-1];
   assign mosi_s  = mosi_sync[SYNC_STAGES-1];
   assign rise    = sclk_s & ~sclk_d;
   assign fall    = ~sclk_s & sclk_d;
   assign cs_rise = cs_s & ~cs_d;
   assign cs_fall = ~cs_s & cs_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) ch[i] <= RESET_VALUE;
      end else if (wr_en) begin
         ch[wr_addr] <= wr_data;
      end
   end

   // pseudo-differential pairs are (0,1) and (2,3); D0 picks the minuend
   assign ch_a   = ch[cmd[1:0]];
   assign ch_b   = ch[{cmd[1], ~cmd[0]}];
   assign diff   = {1'b0, ch_a} - {1'b0, ch_b};
   assign result = cmd[2] ? ch_a : (diff[12] ? 12'h000 : diff[11:0]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         cmd        <= '0;
         sh         <= '0;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
         conv_done  <= 1'b0;
         conv_chan  <= '0;
         conv_count <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         cmd        <= cmd_n;
         sh         <= sh_n;
         miso_q     <= miso_n;
         oe_q       <= oe_n;
         conv_done  <= done_n;
         conv_chan  <= chan_n;
         conv_count <= count_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cmd_n   = cmd;
      sh_n    = sh;
      miso_n  = miso_q;
      oe_n    = oe_q;
      done_n  = 1'b0;
      chan_n  = conv_chan;
      count_n = conv_count;
      unique case (state)
         IDLE: begin
            if (cs_fall) state_n = WAIT_START;
         end
         WAIT_START: begin
            if (rise && mosi_s) begin
               state_n = CMD;
               cnt_n   = '0;
            end
         end
         CMD: begin
            if (rise) begin
               case (cnt[1:0])
                  2'd0:    cmd_n[2] = mosi_s;
                  2'd2:    cmd_n[1] = mosi_s;
                  2'd3:    cmd_n[0] = mosi_s;
                  default: ;
               endcase
               cnt_n = cnt + 4'd1;
               if (cnt == 4'd3) begin
                  state_n = SAMPLE;
                  cnt_n   = '0;
               end
            end
         end
         SAMPLE: begin
            if (rise && cnt == 4'd0) begin
               sh_n  = result;
               cnt_n = 4'd1;
            end else if (fall && cnt == 4'd1) begin
               miso_n  = 1'b0;
               oe_n    = 1'b1;
               state_n = DATA;
               cnt_n   = '0;
            end
         end
         DATA: begin
            if (fall && cnt != 4'd12) begin
               miso_n = sh[11];
               sh_n   = {sh[10:0], 1'b0};
               cnt_n  = cnt + 4'd1;
            end else if (rise && cnt == 4'd12) begin
               done_n  = 1'b1;
               chan_n  = cmd;
               count_n = conv_count + COUNT_WIDTH'(1);
               state_n = TRAIL;
            end
         end
         TRAIL: begin
            if (fall) miso_n = 1'b0;
         end
         default: state_n = IDLE;
      endcase
      if (cs_rise) begin
         state_n = IDLE;
         miso_n  = 1'b0;
         oe_n    = 1'b0;
      end
   end

   assign spi.miso    = miso_q;
   assign spi.miso_oe = oe_q;

endmodule
